fd_instr_queue: RTL and testbench

- Small instruction FIFO between the fetch stage (instruction ROM + PC register) and the decode stage of the 5-stage MIPS pipeline.
- Absorbs decode stalls without freezing the PC in the same cycle: fetch write-enable is driven from queue space.
- Supports branch/jump redirect flushes, with optional preservation of exactly one delay-slot instruction.

---
 rtl/fd_instr_queue_pkg.sv | 12 +
 rtl/fd_instr_queue.sv | 99 +++++++++
 tb/tb_fd_instr_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fd_instr_queue_pkg.sv
// Shared fetch/decode definitions: reset PC, the nop encoding and the fetch packet layout.
package fd_instr_queue_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/fd_instr_queue.sv
// Fetch-to-decode instruction FIFO with redirect flush and optional delay-slot retention.
// Fetch is throttled by queue space; decode sees the head entry combinationally.
module fd_instr_queue
   import fd_instr_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               F_pc,
   input  logic [31:0]               F_instr,
   input  logic                      F_valid,
   output logic                      F_ready,
   output logic [31:0]               D_pc,
   output logic [31:0]               D_instr,
   output logic                      D_valid,
   input  logic                      D_ready,
   input  logic                      flush,
   input  logic                      flush_keep_one,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

   fetch_pkt_t          r_mem [DEPTH];
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W:0]      r_count;

   logic                w_push;
   logic                w_pop;
   logic [PTR_W-1:0]    w_rd_after_pop;
   logic [PTR_W:0]      w_remaining;
   logic                w_mem_we;
   fetch_pkt_t          w_head;

   assign F_ready = (r_count != FULL_CNT);
   assign D_valid = (r_count != '0);
   assign count   = r_count;

   assign w_push = F_valid & F_ready;
   assign w_pop  = D_valid & D_ready;

   assign w_rd_after_pop = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
   assign w_remaining    = r_count - (PTR_W+1)'(w_pop);

   // With keep-one, the incoming push only survives when nothing older remains.
   assign w_mem_we = w_push & ~reset &
                     (~flush | (flush_keep_one & (w_remaining == '0)));

   assign w_head  = r_mem[r_rd_ptr];
   assign D_pc    = D_valid ? w_head.pc    : 32'h0000_0000;
   assign D_instr = D_valid ? w_head.instr : NOP;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_wr_ptr] <= '{pc: F_pc, instr: F_instr};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         if (!flush_keep_one) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
         end else if (w_remaining != '0) begin
            // Oldest queued survivor stays in place as the sole entry.
            r_rd_ptr <= w_rd_after_pop;
            r_wr_ptr <= w_rd_after_pop + PTR_ONE;
            r_count  <= CNT_ONE;
         end else if (w_push) begin
            r_rd_ptr <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
            r_count  <= CNT_ONE;
         end else begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
         end
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         r_rd_ptr <= w_rd_after_pop;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fd_instr_queue.sv
// Directed bench for fd_instr_queue: stimulus pushes expected packets to a scoreboard,
// a negedge monitor checks every packet decode consumes; occupancy is checked directly.
module tb_fd_instr_queue;
   import fd_instr_queue_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   F_pc;
   logic [31:0]   F_instr;
   logic          F_valid;
   logic          F_ready;
   logic [31:0]   D_pc;
   logic [31:0]   D_instr;
   logic          D_valid;
   logic          D_ready;
   logic          flush;
   logic          flush_keep_one;
   logic [2:0]    count;

   int            n_cmp = 0;
   int            n_err = 0;
   fetch_pkt_t    exp_q[$];

   fd_instr_queue #(.DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .F_pc           (F_pc),
      .F_instr        (F_instr),
      .F_valid        (F_valid),
      .F_ready        (F_ready),
      .D_pc           (D_pc),
      .D_instr        (D_instr),
      .D_valid        (D_valid),
      .D_ready        (D_ready),
      .flush          (flush),
      .flush_keep_one (flush_keep_one),
      .count          (count)
   );

   always #5 clk = ~clk;

   // Monitor: every consumed head must match the oldest expected packet.
   always @(negedge clk) begin
      if (D_valid && D_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got pc=%h instr=%h, required no output", D_pc, D_instr);
         end else begin
            fetch_pkt_t e;
            e = exp_q.pop_front();
            if (D_pc !== e.pc || D_instr !== e.instr) begin
               n_err++;
               $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                        D_pc, D_instr, e.pc, e.instr);
            end else begin
               $display("pop pc=%h instr=%h ok", D_pc, D_instr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end else begin
         $display("check %s = %h ok", name, act);
      end
   endtask

   task automatic drive_push(input logic [31:0] pc, input logic [31:0] instr, input bit expect_kept);
      F_valid = 1'b1;
      F_pc    = pc;
      F_instr = instr;
      if (expect_kept) exp_q.push_back('{pc: pc, instr: instr});
   endtask

   task automatic idle_inputs();
      F_valid = 1'b0;
      D_ready = 1'b0;
      flush = 1'b0;
      flush_keep_one = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      F_pc = '0;
      F_instr = '0;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_D_valid", 32'(D_valid), 32'd0);
      chk("reset_F_ready", 32'(F_ready), 32'd1);
      chk("reset_D_instr", D_instr, 32'h0);
      chk("reset_D_pc", D_pc, 32'h0);

      // Three pushes with decode stalled
      for (int i = 0; i < 3; i++) begin
         drive_push(RESET_PC + 32'(4*i), 32'h11 * 32'(i+1), 1'b1);
         tick();
      end
      F_valid = 1'b0;
      chk("three_count", 32'(count), 32'd3);
      chk("three_D_pc", D_pc, 32'h3000);
      chk("three_D_instr", D_instr, 32'h11);
      chk("three_F_ready", 32'(F_ready), 32'd1);

      // Fill, then a fifth offer must be ignored
      drive_push(32'h300C, 32'h44, 1'b1);
      tick();
      chk("full_count", 32'(count), 32'd4);
      chk("full_F_ready", 32'(F_ready), 32'd0);
      drive_push(32'h3010, 32'h55, 1'b0);
      tick();
      F_valid = 1'b0;
      chk("full_ignore_count", 32'(count), 32'd4);
      chk("full_ignore_D_pc", D_pc, 32'h3000);
      D_ready = 1'b1;
      repeat (4) tick();
      D_ready = 1'b0;
      chk("drain_D_valid", 32'(D_valid), 32'd0);
      chk("drain_D_instr", D_instr, 32'h0);
      chk("drain_count", 32'(count), 32'd0);

      // Streaming push+pop across several pointer wraps
      drive_push(32'h3000, 32'hA0, 1'b1);
      tick();
      D_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         drive_push(32'h3000 + 32'(4*i), 32'hA0 + 32'(i), 1'b1);
         tick();
         chk("stream_count", 32'(count), 32'd1);
         chk("stream_D_pc", D_pc, 32'h3000 + 32'(4*i));
      end
      F_valid = 1'b0;
      tick();
      D_ready = 1'b0;
      chk("stream_end_count", 32'(count), 32'd0);

      // Flush with keep-one while popping and pushing: 0x3014 survives
      for (int i = 0; i < 3; i++) begin
         drive_push(32'h3010 + 32'(4*i), 32'hB0 + 32'(i), 1'b1);
         tick();
      end
      drive_push(32'h301C, 32'hB3, 1'b0);
      D_ready = 1'b1;
      flush = 1'b1;
      flush_keep_one = 1'b1;
      tick();
      idle_inputs();
      exp_q.delete();
      exp_q.push_back('{pc: 32'h3014, instr: 32'hB1});
      chk("keep_old_count", 32'(count), 32'd1);
      chk("keep_old_D_pc", D_pc, 32'h3014);
      chk("keep_old_D_instr", D_instr, 32'hB1);
      D_ready = 1'b1;
      tick();
      D_ready = 1'b0;
      chk("keep_old_drained", 32'(count), 32'd0);

      // Flush on empty queue: keep-one retains the incoming push, plain flush drops it
      drive_push(32'h3020, 32'hC0, 1'b1);
      flush = 1'b1;
      flush_keep_one = 1'b1;
      tick();
      idle_inputs();
      chk("keep_new_count", 32'(count), 32'd1);
      chk("keep_new_D_pc", D_pc, 32'h3020);
      D_ready = 1'b1;
      tick();
      D_ready = 1'b0;
      drive_push(32'h3024, 32'hC1, 1'b0);
      flush = 1'b1;
      flush_keep_one = 1'b0;
      tick();
      idle_inputs();
      chk("drop_count", 32'(count), 32'd0);
      chk("drop_F_ready", 32'(F_ready), 32'd1);
      chk("drop_D_valid", 32'(D_valid), 32'd0);

      // Reset beats flush/push/pop; first push afterwards is the new head
      for (int i = 0; i < 3; i++) begin
         drive_push(32'h3030 + 32'(4*i), 32'hD0 + 32'(i), 1'b1);
         tick();
      end
      drive_push(32'h303C, 32'hD3, 1'b0);
      D_ready = 1'b1;
      flush = 1'b1;
      flush_keep_one = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      exp_q.delete();
      chk("rst_mid_count", 32'(count), 32'd0);
      chk("rst_mid_D_valid", 32'(D_valid), 32'd0);
      drive_push(32'h3000, 32'hE0, 1'b1);
      tick();
      F_valid = 1'b0;
      chk("post_rst_D_pc", D_pc, 32'h3000);
      chk("post_rst_count", 32'(count), 32'd1);
      D_ready = 1'b1;
      tick();
      D_ready = 1'b0;
      tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
